// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage and the divider.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               signed_div;
  logic [WIDTH-1:0]   div_srca;
  logic [WIDTH-1:0]   div_srcb;
  logic               annul;
  logic [2*WIDTH-1:0] div_result;
  logic               div_ready;

  // Execute stage side: issues requests, consumes {HI, LO}.
  modport master (
    output start, signed_div, div_srca, div_srcb, annul,
    input  div_result, div_ready
  );

  // Divider side.
  modport slave (
    input  start, signed_div, div_srca, div_srcb, annul,
    output div_result, div_ready
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU. Operates on the
// magnitudes of the operands and applies the sign correction on the final
// iteration, so the result lands directly in {remainder, quotient} = {HI, LO}.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  div_unit_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   rem_reg, rem_next;
  logic [WIDTH-1:0]   quo_reg, quo_next;
  logic [WIDTH-1:0]   dsr_reg, dsr_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic               neg_q_reg, neg_q_next;
  logic               neg_r_reg, neg_r_next;
  logic [2*WIDTH-1:0] result_reg, result_next;
  logic               ready_reg, ready_next;

  // Operand magnitudes; only taken when signed_div is set.
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;

  // One restoring step: shift in the next dividend bit, trial-subtract.
  logic [WIDTH:0]     shifted, trial;
  logic [WIDTH-1:0]   rem_step, quo_step;

  assign a_neg = bus.signed_div & bus.div_srca[WIDTH-1];
  assign b_neg = bus.signed_div & bus.div_srcb[WIDTH-1];
  assign a_abs = a_neg ? -bus.div_srca : bus.div_srca;
  assign b_abs = b_neg ? -bus.div_srcb : bus.div_srcb;

  // Remainder is always below the divisor, so WIDTH+1 bits never overflow.
  assign shifted  = {rem_reg, quo_reg[WIDTH-1]};
  assign trial    = shifted - {1'b0, dsr_reg};
  assign rem_step = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_step = {quo_reg[WIDTH-2:0], ~trial[WIDTH]};

  assign bus.div_result = result_reg;
  assign bus.div_ready  = ready_reg;

  // State and datapath registers; reset abandons any division in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      rem_reg    <= '0;
      quo_reg    <= '0;
      dsr_reg    <= '0;
      cnt_reg    <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      result_reg <= '0;
      ready_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rem_reg    <= rem_next;
      quo_reg    <= quo_next;
      dsr_reg    <= dsr_next;
      cnt_reg    <= cnt_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
      result_reg <= result_next;
      ready_reg  <= ready_next;
    end
  end

  // Next-state and next-register logic; everything holds unless a state acts.
  always_comb begin
    state_next  = state_reg;
    rem_next    = rem_reg;
    quo_next    = quo_reg;
    dsr_next    = dsr_reg;
    cnt_next    = cnt_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    result_next = result_reg;
    ready_next  = ready_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start && !bus.annul) begin
          neg_q_next = a_neg ^ b_neg;
          neg_r_next = a_neg;
          if (bus.div_srcb == '0) begin
            state_next = DIVZERO;
          end else begin
            rem_next   = '0;
            quo_next   = a_abs;
            dsr_next   = b_abs;
            cnt_next   = '0;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (bus.annul) begin
          state_next = IDLE;
          ready_next = 1'b0;
        end else begin
          rem_next = rem_step;
          quo_next = quo_step;
          cnt_next = cnt_reg + CW'(1);
          if (cnt_reg == CW'(WIDTH - 1)) begin
            // Sign fix folded into the last iteration's result load.
            result_next = {neg_r_reg ? -rem_step : rem_step,
                           neg_q_reg ? -quo_step : quo_step};
            ready_next  = 1'b1;
            state_next  = DONE;
          end
        end
      end
      DIVZERO: begin
        if (bus.annul) begin
          state_next = IDLE;
          ready_next = 1'b0;
        end else begin
          result_next = '0;
          ready_next  = 1'b1;
          state_next  = DONE;
        end
      end
      DONE: begin
        if (bus.annul || !bus.start) begin
          state_next = IDLE;
          ready_next = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        ready_next = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide by
// zero, annul, mid-operation reset, operand stability and back-to-back use.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise start with the given operands and wait (bounded) for div_ready.
  // start is left high; edges counts the start-sampling edge as 1.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int edges, output logic [63:0] res);
    bus.signed_div = sgn;
    bus.div_srca   = a;
    bus.div_srcb   = b;
    bus.start      = 1'b1;
    edges = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      edges++;
      if (bus.div_ready) break;
    end
    res = bus.div_result;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (bus.div_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 0", bus.div_ready);
    end
    checks++;
    if (bus.div_result !== 64'h0) begin
      errors++;
      $display("FAIL reset_result: got %h expected %h", bus.div_result, 64'h0);
    end
  endtask

  task automatic test_unsigned();
    int          e;
    logic [63:0] r;
    run_div(1'b0, 32'd7, 32'd2, e, r);
    $display("udiv 7/2 edges=%0d result=%h", e, r);
    checks++;
    if (e !== 33) begin
      errors++;
      $display("FAIL udiv_latency: got %0d expected 33", e);
    end
    checks++;
    if (r !== 64'h00000001_00000003) begin
      errors++;
      $display("FAIL udiv_7_2: got %h expected %h", r, 64'h00000001_00000003);
    end
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.div_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_drop: got %b expected 0", bus.div_ready);
    end
    checks++;
    if (bus.div_result !== 64'h00000001_00000003) begin
      errors++;
      $display("FAIL result_kept_idle: got %h expected %h", bus.div_result, 64'h00000001_00000003);
    end
    run_div(1'b0, 32'hFFFFFFFF, 32'h10, e, r);
    bus.start = 1'b0;
    tick();
    $display("udiv ffffffff/10 edges=%0d result=%h", e, r);
    checks++;
    if (r !== 64'h0000000F_0FFFFFFF) begin
      errors++;
      $display("FAIL udiv_max_16: got %h expected %h", r, 64'h0000000F_0FFFFFFF);
    end
  endtask

  task automatic test_signed();
    int          e;
    logic [63:0] r;
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, e, r);
    bus.start = 1'b0;
    tick();
    $display("sdiv -7/2 edges=%0d result=%h", e, r);
    checks++;
    if (r !== 64'hFFFFFFFF_FFFFFFFD) begin
      errors++;
      $display("FAIL sdiv_m7_2: got %h expected %h", r, 64'hFFFFFFFF_FFFFFFFD);
    end
    checks++;
    if (e !== 33) begin
      errors++;
      $display("FAIL sdiv_latency: got %0d expected 33", e);
    end
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, e, r);
    bus.start = 1'b0;
    tick();
    $display("sdiv 7/-2 edges=%0d result=%h", e, r);
    checks++;
    if (r !== 64'h00000001_FFFFFFFD) begin
      errors++;
      $display("FAIL sdiv_7_m2: got %h expected %h", r, 64'h00000001_FFFFFFFD);
    end
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, e, r);
    bus.start = 1'b0;
    tick();
    $display("sdiv overflow edges=%0d result=%h", e, r);
    checks++;
    if (r !== 64'h00000000_80000000) begin
      errors++;
      $display("FAIL sdiv_overflow: got %h expected %h", r, 64'h00000000_80000000);
    end
  endtask

  // Runs right after test_signed, so the held result is the overflow case.
  task automatic test_annul();
    int          seen;
    int          e;
    logic [63:0] r;
    bus.signed_div = 1'b0;
    bus.div_srca   = 32'd100;
    bus.div_srcb   = 32'd3;
    bus.start      = 1'b1;
    bus.annul      = 1'b1;
    seen = 0;
    for (int i = 0; i < 35; i++) begin
      tick();
      if (bus.div_ready) seen++;
    end
    bus.start = 1'b0;
    bus.annul = 1'b0;
    $display("annul+start in idle ready_cycles=%0d", seen);
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL annul_idle: got %0d ready cycles expected 0", seen);
    end
    bus.start = 1'b1;
    repeat (9) tick();
    bus.annul = 1'b1;
    bus.start = 1'b0;
    tick();
    bus.annul = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.div_ready) seen++;
    end
    $display("annul at busy edge 10 ready_cycles=%0d result=%h", seen, bus.div_result);
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL annul_busy: got %0d ready cycles expected 0", seen);
    end
    checks++;
    if (bus.div_result !== 64'h00000000_80000000) begin
      errors++;
      $display("FAIL annul_result_kept: got %h expected %h", bus.div_result, 64'h00000000_80000000);
    end
    run_div(1'b0, 32'd100, 32'd3, e, r);
    bus.start = 1'b0;
    tick();
    $display("restart 100/3 edges=%0d result=%h", e, r);
    checks++;
    if (e !== 33) begin
      errors++;
      $display("FAIL restart_latency: got %0d expected 33", e);
    end
    checks++;
    if (r !== 64'h00000001_00000021) begin
      errors++;
      $display("FAIL restart_100_3: got %h expected %h", r, 64'h00000001_00000021);
    end
  endtask

  task automatic test_divzero();
    int          e;
    logic [63:0] r;
    for (int s = 0; s < 2; s++) begin
      run_div(s[0], 32'h1234, 32'h0, e, r);
      bus.start = 1'b0;
      tick();
      $display("divzero signed=%0d edges=%0d result=%h", s, e, r);
      checks++;
      if (e !== 2) begin
        errors++;
        $display("FAIL divzero_latency: got %0d expected 2", e);
      end
      checks++;
      if (r !== 64'h0) begin
        errors++;
        $display("FAIL divzero_result: got %h expected %h", r, 64'h0);
      end
      // Reload a nonzero result so the next pass proves the clear.
      run_div(1'b0, 32'd7, 32'd2, e, r);
      bus.start = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    bus.signed_div = 1'b0;
    bus.div_srca   = 32'h1234;
    bus.div_srcb   = 32'h7;
    bus.start      = 1'b1;
    repeat (19) tick();
    rst       = 1'b1;
    bus.start = 1'b0;
    tick();
    rst = 1'b0;
    $display("reset at busy edge 20 ready=%b result=%h", bus.div_ready, bus.div_result);
    checks++;
    if (bus.div_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ready: got %b expected 0", bus.div_ready);
    end
    checks++;
    if (bus.div_result !== 64'h0) begin
      errors++;
      $display("FAIL midreset_result: got %h expected %h", bus.div_result, 64'h0);
    end
  endtask

  task automatic test_operand_change();
    int e;
    bus.signed_div = 1'b0;
    bus.div_srca   = 32'd1000;
    bus.div_srcb   = 32'd7;
    bus.start      = 1'b1;
    e = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      e++;
      if (e == 5) begin
        bus.div_srca   = 32'd5;
        bus.div_srcb   = 32'd0;
        bus.signed_div = 1'b1;
      end
      if (bus.div_ready) break;
    end
    $display("operand change 1000/7 edges=%0d result=%h", e, bus.div_result);
    checks++;
    if (e !== 33) begin
      errors++;
      $display("FAIL opchg_latency: got %0d expected 33", e);
    end
    checks++;
    if (bus.div_result !== 64'h00000006_0000008E) begin
      errors++;
      $display("FAIL opchg_result: got %h expected %h", bus.div_result, 64'h00000006_0000008E);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("hold in done cycle %0d ready=%b result=%h", i, bus.div_ready, bus.div_result);
      checks++;
      if (bus.div_ready !== 1'b1 || bus.div_result !== 64'h00000006_0000008E) begin
        errors++;
        $display("FAIL done_hold: got ready=%b result=%h expected ready=1 result=%h",
                 bus.div_ready, bus.div_result, 64'h00000006_0000008E);
      end
    end
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.div_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_release: got %b expected 0", bus.div_ready);
    end
  endtask

  task automatic test_back_to_back();
    int          e;
    logic [63:0] r;
    run_div(1'b0, 32'd100, 32'd3, e, r);
    bus.start = 1'b0;
    tick();
    $display("b2b first 100/3 edges=%0d result=%h", e, r);
    checks++;
    if (r !== 64'h00000001_00000021) begin
      errors++;
      $display("FAIL b2b_first: got %h expected %h", r, 64'h00000001_00000021);
    end
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, e, r);
    bus.start = 1'b0;
    tick();
    $display("b2b second -7/2 edges=%0d result=%h", e, r);
    checks++;
    if (e !== 33) begin
      errors++;
      $display("FAIL b2b_latency: got %0d expected 33", e);
    end
    checks++;
    if (r !== 64'hFFFFFFFF_FFFFFFFD) begin
      errors++;
      $display("FAIL b2b_second: got %h expected %h", r, 64'hFFFFFFFF_FFFFFFFD);
    end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.div_srca   = '0;
    bus.div_srcb   = '0;
    bus.annul      = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_annul();
    test_divzero();
    test_reset_mid();
    test_operand_change();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider serving the execute stage's DIV/DIVU path.
- Accepts start, signedness and two operands from the execute stage, then computes over WIDTH iterations.
- Returns {remainder, quotient} with a ready flag, which the execute stage writes into HI/LO.
- Sits beside the execute stage. The execute stage holds start high and stalls the pipeline until ready is seen.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; held high by the requester until ready is observed.
- signed_div  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- div_srca  in  WIDTH  dividend; sampled with start.
- div_srcb  in  WIDTH  divisor; sampled with start.
- annul  in  1  cancel the in-flight division (pipeline flush/exception).
- div_result  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}, i.e. {HI, LO}.
- div_ready  out  1  result valid.

Behaviour:
- States: IDLE, DIVZERO, BUSY, DONE. All outputs are registered.
- Reset (rst=1 at an edge), from any state:
  - state=IDLE, div_ready=0, div_result=0, iteration counter=0.
  - Any operation in progress is abandoned.
- IDLE, start=1 and annul=0 at the edge:
  - Latch signed_div and the operands.
  - If div_srcb==0: go to DIVZERO.
  - Otherwise: load |dividend| and |divisor| (two's-complement absolute value only when signed_div=1), clear the partial remainder, set counter=0, go to BUSY.
  - start=0 or annul=1: stay in IDLE.
- BUSY, each edge:
  - Shift {rem,quo} left by 1.
  - Trial subtract the divisor from rem[WIDTH:0] (WIDTH+1-bit compare).
  - If non-negative: keep the difference and set quo LSB=1; else restore and set quo LSB=0.
  - Increment the counter. After iteration WIDTH-1 (the WIDTH-th edge in BUSY), go to DONE.
- Sign fix, applied on the transition into DONE (signed only):
  - Quotient is negated if the operand signs differ.
  - Remainder is negated if the dividend was negative.
  - Then div_result is loaded and div_ready=1.
- DIVZERO: the next edge goes to DONE with div_result=0 and div_ready=1. No error is signalled (MIPS result undefined).
- DONE:
  - div_ready=1; div_result is held.
  - start=1: stay in DONE.
  - start=0: go to IDLE and clear div_ready; div_result keeps its value.
  - The execute stage drops start in the same cycle it sees ready, so DONE normally lasts one cycle.
- Latency:
  - Nonzero divisor: div_ready rises after edge WIDTH+1, counting the start-sampling edge as edge 1 (33 edges for WIDTH=32).
  - Zero divisor: div_ready rises after edge 2.
- Operand or signed_div changes while in BUSY, DIVZERO or DONE are ignored; only the values latched in IDLE are used.
- annul=1 in BUSY, DIVZERO or DONE: go to IDLE at the next edge, div_ready=0 (no ready pulse), div_result unchanged.
- annul=1 together with start=1 in IDLE: remain in IDLE.
- Signed overflow (0x80000000 / 0xFFFFFFFF): produce q=0x80000000, r=0, which falls out of the absolute-value algorithm. No exception.
- A back-to-back request (start re-asserted in the cycle after DONE→IDLE) is accepted normally.

Test Plan:
- Unsigned 7/2, start held until ready → div_ready first high after edge 33; div_result=64'h00000001_00000003; start dropped → div_ready=0 next edge.
- Signed 0xFFFFFFF9 (−7) / 2 → div_result=64'hFFFFFFFF_FFFFFFFD; signed 7 / 0xFFFFFFFE (−2) → 64'h00000001_FFFFFFFD.
- Unsigned 0xFFFFFFFF / 0x10 → 64'h0000000F_0FFFFFFF; signed 0x80000000 / 0xFFFFFFFF → 64'h00000000_80000000.
- Divisor 0 (either signedness), dividend 0x1234 → div_ready high after edge 2, div_result=0.
- Start 100/3, pulse annul at BUSY edge 10 → IDLE, no ready for 40 cycles; restart 100/3 → 64'h00000001_00000021 after 33 edges.
- rst=1 at BUSY edge 20 → div_ready=0 and div_result=0 next edge; operand changes mid-BUSY → result matches the latched operands; start held in DONE → div_ready stays 1 and the result is stable.
